// File: rtl/btn_debounce.sv
// btn_debounce: debounces 3 buttons and 2 switches; emits press, release, auto-repeat and change pulses.
module btn_debounce #(
  parameter int DB_CYCLES     = 1000000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [3:1] buttons,
  input  logic [1:0] switches,
  output logic [3:1] btn_level,
  output logic [3:1] btn_press,
  output logic [3:1] btn_release,
  output logic [3:1] btn_repeat,
  output logic [1:0] sw_level,
  output logic [1:0] sw_change
);
  localparam int CW = $clog2(DB_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, RPT = 2'd2;
  logic [4:0] raw, lvl_d, lvl_q;
  logic [2:0] prs_d, prs_q, rel_d, rel_q, rpt_d, rpt_q;
  logic [1:0] swc_d, swc_q;
  assign raw = {switches, buttons};
  for (genvar i = 0; i < 5; i++) begin : g_db
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done;
    always_comb begin
      done  = raw[i] != lvl_q[i] && cnt_q == CW'(DB_CYCLES - 1);
      cnt_d = (raw[i] == lvl_q[i] || done) ? '0 : cnt_q + 1'b1;
    end
    assign lvl_d[i] = done ? raw[i] : lvl_q[i];
    always_ff @(posedge clk or posedge rst_a)
      if (rst_a) cnt_q <= '0;
      else cnt_q <= cnt_d;
  end
  always_comb begin
    prs_d = lvl_d[2:0] & ~lvl_q[2:0];
    rel_d = ~lvl_d[2:0] & lvl_q[2:0];
    swc_d = lvl_d[4:3] ^ lvl_q[4:3];
  end
  for (genvar b = 0; b < 3; b++) begin : g_fsm
    logic [1:0]    st_q, st_d;
    logic [HW-1:0] hc_q, hc_d, lim;
    logic          hit;
    always_comb begin
      lim  = (st_q == DOWN) ? HW'(HOLD_CYCLES - 1) : HW'(REPEAT_CYCLES - 1);
      hit  = st_q != UP && lvl_d[b] && hc_q == lim;
      st_d = (st_q == UP) ? (prs_d[b] ? DOWN : UP) : (!lvl_d[b] ? UP : (hit ? RPT : st_q));
      hc_d = (st_q == UP || !lvl_d[b] || hit) ? '0 : hc_q + 1'b1;
    end
    assign rpt_d[b] = hit;
    always_ff @(posedge clk or posedge rst_a)
      if (rst_a) begin
        st_q <= UP;
        hc_q <= '0;
      end else begin
        st_q <= st_d;
        hc_q <= hc_d;
      end
  end
  always_ff @(posedge clk or posedge rst_a)
    if (rst_a) {lvl_q, prs_q, rel_q, rpt_q, swc_q} <= '0;
    else {lvl_q, prs_q, rel_q, rpt_q, swc_q} <= {lvl_d, prs_d, rel_d, rpt_d, swc_d};
  assign btn_level   = lvl_q[2:0];
  assign btn_press   = prs_q;
  assign btn_release = rel_q;
  assign btn_repeat  = rpt_q;
  assign sw_level    = lvl_q[4:3];
  assign sw_change   = swc_q;
endmodule
